pb_debounce: RTL and testbench

Push-button debouncer and one-shot generator with optional auto-repeat. It takes a raw, bouncing, asynchronous button level and produces three registered outputs:
- a clean level;
- a one-cycle press pulse, repeated while the button is held;
- a one-cycle release pulse.

It sits directly downstream of the board reset conditioner, whose synchronized reset drives `rst`, and feeds user-interface logic that needs exactly one event per press.

---
 rtl/pb_pkg.sv | 24 ++
 rtl/btn_sync.sv | 34 +++
 rtl/pb_debounce.sv | 161 ++++++++++++++++
 tb/tb_pb_debounce.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_pkg
// Description : Shared types and default timing constants for the push-button
//               debouncer and related board-input conditioning blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_pkg;

    // Debounce / auto-repeat controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } pb_state_t;

    // Defaults for a 50 MHz system clock
    localparam int DB_CYCLES_50M = 500_000;     // 10 ms debounce window
    localparam int RPT_DLY_50M   = 25_000_000;  // 500 ms until first repeat
    localparam int RPT_PER_50M   = 5_000_000;   // 100 ms between repeats

endpackage : pb_pkg
`default_nettype wire

// File: rtl/btn_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_sync
// Description : Two-flop synchronizer for asynchronous board inputs. Each bit
//               is synchronized independently; reset clears both stages.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a full cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : btn_sync
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
// Module      : pb_debounce
// Description : Push-button debouncer and one-shot generator. Produces a clean
//               level, a one-cycle press pulse (repeated while held when
//               auto-repeat is enabled) and a one-cycle release pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce
    import pb_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_50M,
    parameter int RPT_EN    = 1,
    parameter int RPT_DLY   = RPT_DLY_50M,
    parameter int RPT_PER   = RPT_PER_50M,
    parameter int CNT_W     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_lvl,
    output logic btn_press,
    output logic btn_rel
);

    // Terminal counts; compare-and-clear happens before increment so the
    // counters never need to exceed these values.
    localparam logic [CNT_W-1:0] c_DB_LAST      = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RPT_DLY_LAST = CNT_W'(RPT_DLY - 1);
    localparam logic [CNT_W-1:0] c_RPT_PER_LAST = CNT_W'(RPT_PER - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);

    logic             w_s;

    pb_state_t        r_state;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_first;
    logic             r_lvl;
    logic             r_press;
    logic             r_rel;

    pb_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             w_first_nxt;
    logic             w_lvl_nxt;
    logic             w_press_nxt;
    logic             w_rel_nxt;
    logic [CNT_W-1:0] w_rpt_last;

    btn_sync #(
        .WIDTH (1)
    ) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .i_d (btn_in),
        .o_q (w_s)
    );

    // First repeat waits the long delay, later ones use the short period
    assign w_rpt_last = r_first ? c_RPT_DLY_LAST : c_RPT_PER_LAST;

    // Next-state, counter and output-pulse decode
    always_comb begin
        w_state_nxt   = r_state;
        w_db_cnt_nxt  = r_db_cnt;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_first_nxt   = r_first;
        w_lvl_nxt     = r_lvl;
        w_press_nxt   = 1'b0;
        w_rel_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                w_lvl_nxt = 1'b0;
                if (w_s) begin
                    w_state_nxt  = DB_PRESS;
                    w_db_cnt_nxt = '0;
                end
            end

            DB_PRESS: begin
                if (!w_s) begin
                    // Bounce: fall back silently
                    w_state_nxt = IDLE;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt   = HELD;
                    w_lvl_nxt     = 1'b1;
                    w_press_nxt   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                    w_first_nxt   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_CNT_ONE;
                end
            end

            HELD: begin
                w_lvl_nxt = 1'b1;
                if (!w_s) begin
                    // Repeat counter freezes while the release is being qualified
                    w_state_nxt  = DB_REL;
                    w_db_cnt_nxt = '0;
                end else if (RPT_EN != 0) begin
                    if (r_rpt_cnt == w_rpt_last) begin
                        w_press_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                        w_first_nxt   = 1'b0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + c_CNT_ONE;
                    end
                end
            end

            DB_REL: begin
                if (w_s) begin
                    // Release bounce: resume holding, repeat count intact
                    w_state_nxt = HELD;
                end else if (r_db_cnt == c_DB_LAST) begin
                    w_state_nxt = IDLE;
                    w_lvl_nxt   = 1'b0;
                    w_rel_nxt   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_lvl_nxt   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            r_rpt_cnt <= '0;
            r_first   <= 1'b0;
            r_lvl     <= 1'b0;
            r_press   <= 1'b0;
            r_rel     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_first   <= w_first_nxt;
            r_lvl     <= w_lvl_nxt;
            r_press   <= w_press_nxt;
            r_rel     <= w_rel_nxt;
        end
    end

    assign btn_lvl   = r_lvl;
    assign btn_press = r_press;
    assign btn_rel   = r_rel;

endmodule : pb_debounce
`default_nettype wire

// File: tb/tb_pb_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_debounce
// Description : Directed self-checking bench for pb_debounce. Two instances
//               share the stimulus: one without and one with auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_debounce;

    localparam int DBC = 4;
    localparam int DLY = 20;
    localparam int PER = 8;

    logic clk;
    logic rst;
    logic btn_in;

    logic n_lvl, n_press, n_rel;   // RPT_EN = 0 instance
    logic r_lvl, r_press, r_rel;   // RPT_EN = 1 instance

    int n_vec;
    int n_err;

    pb_debounce #(
        .DB_CYCLES (DBC),
        .RPT_EN    (0),
        .RPT_DLY   (DLY),
        .RPT_PER   (PER),
        .CNT_W     (5)
    ) u_dut_norpt (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_lvl   (n_lvl),
        .btn_press (n_press),
        .btn_rel   (n_rel)
    );

    pb_debounce #(
        .DB_CYCLES (DBC),
        .RPT_EN    (1),
        .RPT_DLY   (DLY),
        .RPT_PER   (PER),
        .CNT_W     (5)
    ) u_dut_rpt (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_lvl   (r_lvl),
        .btn_press (r_press),
        .btn_rel   (r_rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset both instances; returns on a falling edge with rst low, btn_in low
    task automatic apply_reset();
        @(negedge clk);
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 6;
        if (n_lvl !== 1'b0)   begin n_err++; $display("FAIL reset norpt btn_lvl: got %b want 0", n_lvl); end
        if (n_press !== 1'b0) begin n_err++; $display("FAIL reset norpt btn_press: got %b want 0", n_press); end
        if (n_rel !== 1'b0)   begin n_err++; $display("FAIL reset norpt btn_rel: got %b want 0", n_rel); end
        if (r_lvl !== 1'b0)   begin n_err++; $display("FAIL reset rpt btn_lvl: got %b want 0", r_lvl); end
        if (r_press !== 1'b0) begin n_err++; $display("FAIL reset rpt btn_press: got %b want 0", r_press); end
        if (r_rel !== 1'b0)   begin n_err++; $display("FAIL reset rpt btn_rel: got %b want 0", r_rel); end
        rst = 1'b0;
    endtask

    // Press accepted at edge 7, single pulse, no repeats with RPT_EN=0
    task automatic test_clean_press();
        logic e_press, e_lvl;
        apply_reset();
        btn_in = 1'b1;
        for (int k = 1; k <= 107; k++) begin
            @(posedge clk); #1;
            e_press = (k == DBC + 3);
            e_lvl   = (k >= DBC + 3);
            n_vec += 3;
            if (n_press !== e_press) begin n_err++; $display("FAIL clean_press btn_press edge %0d: got %b want %b", k, n_press, e_press); end
            if (n_lvl !== e_lvl)     begin n_err++; $display("FAIL clean_press btn_lvl edge %0d: got %b want %b", k, n_lvl, e_lvl); end
            if (n_rel !== 1'b0)      begin n_err++; $display("FAIL clean_press btn_rel edge %0d: got %b want 0", k, n_rel); end
        end
    endtask

    // Continues from HELD: release accepted at edge 7 after first low sample
    task automatic test_release();
        logic e_rel, e_lvl;
        btn_in = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e_rel = (k == DBC + 3);
            e_lvl = (k < DBC + 3);
            n_vec += 3;
            if (n_rel !== e_rel)     begin n_err++; $display("FAIL release btn_rel edge %0d: got %b want %b", k, n_rel, e_rel); end
            if (n_lvl !== e_lvl)     begin n_err++; $display("FAIL release btn_lvl edge %0d: got %b want %b", k, n_lvl, e_lvl); end
            if (n_press !== 1'b0)    begin n_err++; $display("FAIL release btn_press edge %0d: got %b want 0", k, n_press); end
        end
    endtask

    // 1,0,1,0 every 2 cycles then low: nothing may be accepted
    task automatic test_bounce();
        logic [7:0] pat;
        apply_reset();
        pat = 8'b0011_0011;   // bit k-1 drives edge k
        btn_in = pat[0];
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            n_vec += 4;
            if (n_lvl !== 1'b0 || r_lvl !== 1'b0)     begin n_err++; $display("FAIL bounce btn_lvl edge %0d: got %b/%b want 0", k, n_lvl, r_lvl); end
            if (n_press !== 1'b0 || r_press !== 1'b0) begin n_err++; $display("FAIL bounce btn_press edge %0d: got %b/%b want 0", k, n_press, r_press); end
            if (n_rel !== 1'b0)                       begin n_err++; $display("FAIL bounce norpt btn_rel edge %0d: got %b want 0", k, n_rel); end
            if (r_rel !== 1'b0)                       begin n_err++; $display("FAIL bounce rpt btn_rel edge %0d: got %b want 0", k, r_rel); end
            btn_in = (k < 8) ? pat[k] : 1'b0;
        end
    endtask

    // Accept at A=7, repeats at A+20 then every 8 edges
    task automatic test_auto_repeat();
        logic e_press, e_lvl;
        apply_reset();
        btn_in = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            @(posedge clk); #1;
            e_press = (k == 7) || (k >= 27 && ((k - 27) % 8) == 0);
            e_lvl   = (k >= 7);
            n_vec += 3;
            if (r_press !== e_press) begin n_err++; $display("FAIL auto_repeat btn_press edge %0d: got %b want %b", k, r_press, e_press); end
            if (r_lvl !== e_lvl)     begin n_err++; $display("FAIL auto_repeat btn_lvl edge %0d: got %b want %b", k, r_lvl, e_lvl); end
            if (r_rel !== 1'b0)      begin n_err++; $display("FAIL auto_repeat btn_rel edge %0d: got %b want 0", k, r_rel); end
        end
    endtask

    // Async reset mid-cycle (once in HELD, once in DB_PRESS), then full re-debounce
    task automatic test_reset_mid();
        int stop_k;
        logic e_press, e_lvl;
        apply_reset();
        btn_in = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            stop_k = (ph == 0) ? 7 : 4;
            for (int k = 1; k <= stop_k; k++) begin
                @(posedge clk); #1;
            end
            n_vec += 1;
            if (r_lvl !== (ph == 0)) begin n_err++; $display("FAIL reset_mid pre btn_lvl phase %0d: got %b want %b", ph, r_lvl, (ph == 0)); end
            #2;
            rst = 1'b1;
            #1;
            n_vec += 3;
            if (r_lvl !== 1'b0)   begin n_err++; $display("FAIL reset_mid async btn_lvl phase %0d: got %b want 0", ph, r_lvl); end
            if (r_press !== 1'b0) begin n_err++; $display("FAIL reset_mid async btn_press phase %0d: got %b want 0", ph, r_press); end
            if (r_rel !== 1'b0)   begin n_err++; $display("FAIL reset_mid async btn_rel phase %0d: got %b want 0", ph, r_rel); end
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                e_press = (k == DBC + 3);
                e_lvl   = (k >= DBC + 3);
                n_vec += 2;
                if (r_press !== e_press) begin n_err++; $display("FAIL reset_mid after btn_press phase %0d edge %0d: got %b want %b", ph, k, r_press, e_press); end
                if (r_lvl !== e_lvl)     begin n_err++; $display("FAIL reset_mid after btn_lvl phase %0d edge %0d: got %b want %b", ph, k, r_lvl, e_lvl); end
            end
            // Restart counting from a known point for the next phase
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // Low samples at edges 15..17: HELD exits at 17, returns at 20, so the
    // repeat counter misses edges 17..20 and the first repeat moves 27 -> 31
    task automatic test_release_bounce();
        logic e_press, e_lvl;
        apply_reset();
        btn_in = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            e_press = (k == 7) || (k == 31) || (k == 39) || (k == 47);
            e_lvl   = (k >= 7);
            n_vec += 3;
            if (r_press !== e_press) begin n_err++; $display("FAIL release_bounce btn_press edge %0d: got %b want %b", k, r_press, e_press); end
            if (r_lvl !== e_lvl)     begin n_err++; $display("FAIL release_bounce btn_lvl edge %0d: got %b want %b", k, r_lvl, e_lvl); end
            if (r_rel !== 1'b0)      begin n_err++; $display("FAIL release_bounce btn_rel edge %0d: got %b want 0", k, r_rel); end
            btn_in = (k >= 14 && k <= 16) ? 1'b0 : 1'b1;
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_auto_repeat();
        test_reset_mid();
        test_release_bounce();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pb_debounce
`default_nettype wire
